// File: rtl/alu_exec_seq_if.sv
// Execute-stage ALU handshake bundle: operation in (valid/ready), result out (valid/ready), busy status.
// master = issuing side (register-read / testbench), slave = the ALU.
interface alu_exec_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [1:0]      alu_op_cls;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, instr, alu_op_cls, opa, opb, out_ready,
    input  in_ready, out_valid, result, illegal, busy
  );

  modport slave (
    input  in_valid, instr, alu_op_cls, opa, opb, out_ready,
    output in_ready, out_valid, result, illegal, busy
  );
endinterface

// File: rtl/alu_exec_seq.sv
// Decoding ALU with registered valid/ready result; ALU_EXEC_MEXT_EN adds RV32M mul and an iterative divider.
// Latency 1 cycle (long divides 1+XLEN/DIV_UNROLL); accepts only in IDLE when the output slot is free or draining.
module alu_exec_seq #(
  parameter int XLEN       = 32,
  parameter int DIV_UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_seq_if.slave bus
);

  localparam int SHW   = $clog2(XLEN);
  localparam int ITER  = XLEN / DIV_UNROLL;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef ALU_EXEC_MEXT_EN
    ,S_DIV = 2'd2
`endif
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_e;

  state_e          state, state_nxt;
  op_e             op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a, b, alu_res;
  logic [SHW-1:0]  sh;
  logic            fire_in, fire_out;
  logic            out_vld_q, vld_nxt, ill_q, ill_nxt;
  logic [XLEN-1:0] res_q, res_nxt;
  logic            unused_bits;

  assign funct3      = bus.instr[14:12];
  assign funct7      = bus.instr[31:25];
  assign a           = bus.opa;
  assign b           = bus.opb;
  assign sh          = bus.opb[SHW-1:0];
  assign unused_bits = ^{bus.instr[24:15], bus.instr[11:0]};

  always_comb begin
    op = OP_ADD;
    if (bus.alu_op_cls == 2'b00) begin
      op = OP_ADD;
    end else if (bus.alu_op_cls == 2'b01) begin
      op = OP_SUB;
    end else if (bus.alu_op_cls == 2'b10 && funct7 == 7'b0000001) begin
`ifdef ALU_EXEC_MEXT_EN
      case (funct3)
        3'b000:  op = OP_MUL;
        3'b001:  op = OP_MULH;
        3'b010:  op = OP_MULHSU;
        3'b011:  op = OP_MULHU;
        3'b100:  op = OP_DIV;
        3'b101:  op = OP_DIVU;
        3'b110:  op = OP_REM;
        default: op = OP_REMU;
      endcase
`else
      op = OP_ILL;
`endif
    end else if (bus.alu_op_cls == 2'b10 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
      op = OP_ILL;
    end else begin
      // funct7[5] only selects SUB for R-type; I-type ADDI has no subtract form
      case (funct3)
        3'b000:  op = (bus.alu_op_cls == 2'b10 && funct7[5]) ? OP_SUB : OP_ADD;
        3'b001:  op = OP_SLL;
        3'b010:  op = OP_SLT;
        3'b011:  op = OP_SLTU;
        3'b100:  op = OP_XOR;
        3'b101:  op = funct7[5] ? OP_SRA : OP_SRL;
        3'b110:  op = OP_OR;
        default: op = OP_AND;
      endcase
    end
  end

`ifdef ALU_EXEC_MEXT_EN
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              div_sgn, div_long;
  logic [XLEN-1:0]   dq, dr, dd, dq_nxt, dr_nxt, dd_nxt, dq_step, dr_step;
  logic [XLEN:0]     r_sh;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              neg_q, neg_r, is_rem, negq_nxt, negr_nxt, rem_nxt;

  always_comb begin
    mul_a = (op == OP_MULH || op == OP_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    mul_b = (op == OP_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod  = mul_a * mul_b;
  end

  // Divide-by-zero and signed overflow finish in the single-cycle path
  assign div_sgn  = (op == OP_DIV) || (op == OP_REM);
  assign div_long = (op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) &&
                    (b != '0) && !(div_sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1);

  // Restoring divide on magnitudes: dividend bits leave dq's MSB, quotient bits enter its LSB
  always_comb begin
    dq_step = dq;
    dr_step = dr;
    r_sh    = '0;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      r_sh    = {dr_step, dq_step[XLEN-1]};
      dq_step = {dq_step[XLEN-2:0], 1'b0};
      if (r_sh >= {1'b0, dd}) begin
        r_sh       = r_sh - {1'b0, dd};
        dq_step[0] = 1'b1;
      end
      dr_step = r_sh[XLEN-1:0];
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:    alu_res = a + b;
      OP_SUB:    alu_res = a - b;
      OP_SLL:    alu_res = a << sh;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:    alu_res = a ^ b;
      OP_SRL:    alu_res = a >> sh;
      OP_SRA:    alu_res = $signed(a) >>> sh;
      OP_OR:     alu_res = a | b;
      OP_AND:    alu_res = a & b;
`ifdef ALU_EXEC_MEXT_EN
      OP_MUL:    alu_res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
      OP_DIV:    alu_res = (b == '0) ? '1 : a;
      OP_DIVU:   alu_res = '1;
      OP_REM:    alu_res = (b == '0) ? a : '0;
      OP_REMU:   alu_res = a;
`endif
      default:   alu_res = '0;
    endcase
  end

  assign fire_in  = bus.in_valid && bus.in_ready;
  assign fire_out = out_vld_q && bus.out_ready;

  always_comb begin
    state_nxt = state;
    vld_nxt   = out_vld_q;
    res_nxt   = res_q;
    ill_nxt   = ill_q;
`ifdef ALU_EXEC_MEXT_EN
    dq_nxt   = dq;
    dr_nxt   = dr;
    dd_nxt   = dd;
    cnt_nxt  = cnt;
    negq_nxt = neg_q;
    negr_nxt = neg_r;
    rem_nxt  = is_rem;
`endif
    case (state)
      S_IDLE: begin
        if (fire_out) vld_nxt = 1'b0;
        if (fire_in) begin
`ifdef ALU_EXEC_MEXT_EN
          if (div_long) begin
            state_nxt = S_DIV;
            vld_nxt   = 1'b0;
            dq_nxt    = (div_sgn && a[XLEN-1]) ? -a : a;
            dd_nxt    = (div_sgn && b[XLEN-1]) ? -b : b;
            dr_nxt    = '0;
            cnt_nxt   = CNT_W'(ITER);
            negq_nxt  = div_sgn && (a[XLEN-1] ^ b[XLEN-1]);
            negr_nxt  = div_sgn && a[XLEN-1];
            rem_nxt   = (op == OP_REM) || (op == OP_REMU);
          end else
`endif
          begin
            vld_nxt = 1'b1;
            res_nxt = alu_res;
            ill_nxt = (op == OP_ILL);
          end
        end
      end
`ifdef ALU_EXEC_MEXT_EN
      S_DIV: begin
        dq_nxt  = dq_step;
        dr_nxt  = dr_step;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          res_nxt   = is_rem ? (neg_r ? -dr_step : dr_step) : (neg_q ? -dq_step : dq_step);
          ill_nxt   = 1'b0;
          vld_nxt   = 1'b1;
          state_nxt = (out_vld_q && !bus.out_ready) ? S_HOLD : S_IDLE;
        end
      end
`endif
      S_HOLD: begin
        if (bus.out_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      res_q     <= '0;
      ill_q     <= 1'b0;
`ifdef ALU_EXEC_MEXT_EN
      dq        <= '0;
      dr        <= '0;
      dd        <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_rem    <= 1'b0;
`endif
    end else begin
      out_vld_q <= vld_nxt;
      res_q     <= res_nxt;
      ill_q     <= ill_nxt;
`ifdef ALU_EXEC_MEXT_EN
      dq        <= dq_nxt;
      dr        <= dr_nxt;
      dd        <= dd_nxt;
      cnt       <= cnt_nxt;
      neg_q     <= negq_nxt;
      neg_r     <= negr_nxt;
      is_rem    <= rem_nxt;
`endif
    end
  end

  assign bus.in_ready  = rst_n && (state == S_IDLE) && (!out_vld_q || bus.out_ready);
  assign bus.out_valid = out_vld_q;
  assign bus.result    = res_q;
  assign bus.illegal   = ill_q;
`ifdef ALU_EXEC_MEXT_EN
  assign bus.busy      = (state == S_DIV);
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed literal cases plus randomized traffic against a
// queue-based behavioural model (expected result, illegal flag and due cycle per accepted op).
module tb_alu_exec_seq;
  localparam int XLEN = 32;
  localparam int DU   = 1;
  localparam int ITER = XLEN / DU;
`ifdef ALU_EXEC_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_exec_seq_if #(.XLEN(XLEN)) bus();
  alu_exec_seq #(.XLEN(XLEN), .DIV_UNROLL(DU)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] r;
    logic        ill;
    logic        lng;
    int          due;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'h0, f3, 12'h0};
  endfunction

  // Reference semantics written with 64-bit integer arithmetic
  function automatic void model(input logic [1:0] cls, input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output logic ill,
                                output logic lng);
    logic [2:0]  f3;
    logic [6:0]  f7;
    longint      sa, sb, ua, ub;
    logic [63:0] pp;
    int          shamt;
    f3 = ins[14:12]; f7 = ins[31:25];
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    shamt = int'(b[4:0]);
    r = 32'h0; ill = 1'b0; lng = 1'b0; pp = 64'h0;
    if (cls == 2'b00) r = a + b;
    else if (cls == 2'b01) r = a - b;
    else if (cls == 2'b10 && f7 == 7'b0000001) begin
      if (MEXT) begin
        case (f3)
          3'd0: begin pp = sa * sb; r = pp[31:0];  end
          3'd1: begin pp = sa * sb; r = pp[63:32]; end
          3'd2: begin pp = sa * ub; r = pp[63:32]; end
          3'd3: begin pp = ua * ub; r = pp[63:32]; end
          3'd4: begin
            if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
            else begin pp = sa / sb; r = pp[31:0]; end
          end
          3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
          3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
            else begin pp = sa % sb; r = pp[31:0]; end
          end
          default: r = (b == 0) ? a : a % b;
        endcase
        lng = f3[2] && (b != 0) && !(!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
      end else ill = 1'b1;
    end else if (cls == 2'b10 && f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
    else begin
      case (f3)
        3'd0: r = (cls == 2'b10 && f7[5]) ? a - b : a + b;
        3'd1: r = a << shamt;
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          if (f7[5]) begin pp = sa >>> shamt; r = pp[31:0]; end
          else r = a >> shamt;
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  // Compare process: every cycle against the pending-op queue
  always @(negedge clk) begin
    logic exp_ovld, exp_busy, exp_rdy, ill, lng;
    logic [31:0] r;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_in_ready", bus.in_ready, 0);
    end else begin
      exp_ovld = (q.size() > 0) && (cyc >= q[0].due);
      exp_busy = (q.size() > 0) && q[0].lng && (cyc < q[0].due);
      exp_rdy  = !exp_busy && (!exp_ovld || bus.out_ready);
      chk("out_valid", bus.out_valid, exp_ovld);
      chk("busy", bus.busy, exp_busy);
      chk("in_ready", bus.in_ready, exp_rdy);
      if (exp_ovld) begin
        chk("result", bus.result, q[0].r);
        chk("illegal", bus.illegal, q[0].ill);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && exp_rdy) begin
        model(bus.alu_op_cls, bus.instr, bus.opa, bus.opb, r, ill, lng);
        e.r = r; e.ill = ill; e.lng = lng;
        e.due = cyc + 1 + (lng ? ITER : 0);
        q.push_back(e);
      end
    end
  end

  task automatic do_op(input string nm, input logic [1:0] cls, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eill, input int elat);
    int t0, bcnt;
    bit got, seen;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op_cls = cls; bus.instr = ins;
    bus.opa = a; bus.opb = b; bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = bus.in_ready;
    end
    t0 = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_accept"}, got, 1);
    if (!got) return;
    seen = 1'b0; bcnt = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      seen = bus.out_valid;
    end
    chk({nm, "_done"}, seen, 1);
    chk({nm, "_lat"}, cyc - t0, elat);
    chk({nm, "_busy_cycles"}, bcnt, elat - 1);
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_illegal"}, bus.illegal, eill);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic        ill, lng;
    logic [6:0]  f7;
    int          sel;
    bus.in_valid = 1'b0; bus.alu_op_cls = 2'b00; bus.instr = 32'h0;
    bus.opa = 32'h0; bus.opb = 32'h0; bus.out_ready = 1'b1;

    // Pin the model with hand-computed values
    model(2'b10, mk(7'h20, 3'b000), 32'd5, 32'd7, r, ill, lng);
    chk("model_sub", r, 32'hFFFFFFFE);
    model(2'b11, mk(7'h20, 3'b101), 32'h80000000, 32'h24, r, ill, lng);
    chk("model_sra", r, 32'hF8000000);
    model(2'b11, mk(7'h00, 3'b101), 32'h80000000, 32'h24, r, ill, lng);
    chk("model_srl", r, 32'h08000000);
    model(2'b10, mk(7'h01, 3'b100), 32'hFFFFFFF9, 32'd2, r, ill, lng);
    chk("model_div", r, MEXT ? 32'hFFFFFFFD : 32'h0);
    chk("model_div_ill", ill, !MEXT);
    model(2'b10, mk(7'h01, 3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, r, ill, lng);
    chk("model_mulhu", r, MEXT ? 32'hFFFFFFFE : 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;

    do_op("sub", 2'b10, mk(7'h20, 3'b000), 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
    do_op("srai", 2'b11, mk(7'h20, 3'b101), 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1);
    do_op("srli", 2'b11, mk(7'h00, 3'b101), 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1);
    do_op("bad_f7", 2'b10, mk(7'h11, 3'b000), 32'd1, 32'd2, 32'h0, 1'b1, 1);
    if (MEXT) begin
      do_op("div_neg", 2'b10, mk(7'h01, 3'b100), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1 + ITER);
      do_op("rem_neg", 2'b10, mk(7'h01, 3'b110), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1 + ITER);
      do_op("divu_zero", 2'b10, mk(7'h01, 3'b101), 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
      do_op("div_ovf", 2'b10, mk(7'h01, 3'b100), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
      do_op("rem_ovf", 2'b10, mk(7'h01, 3'b110), 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
    end else begin
      do_op("mext_ill", 2'b10, mk(7'h01, 3'b100), 32'hFFFFFFF9, 32'd2, 32'h0, 1'b1, 1);
    end

    // Back-to-back ADDs, then stall the consumer on the second
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op_cls = 2'b00; bus.opa = 32'd1; bus.opb = 32'd1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.opa = 32'd2; bus.opb = 32'd2;
    @(negedge clk);
    chk("b2b_first", bus.result, 32'd2);
    @(posedge clk); #1;
    bus.opa = 32'd9; bus.opb = 32'd9; bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_held", bus.result, 32'd4);
      chk("b2b_held_vld", bus.out_valid, 1);
      chk("b2b_held_rdy", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_release_rdy", bus.in_ready, 1);
    @(negedge clk);
    chk("b2b_drained", bus.out_valid, 0);

    // Reset in the middle of a divide
    if (MEXT) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.alu_op_cls = 2'b10; bus.instr = mk(7'h01, 3'b100);
      bus.opa = 32'd100; bus.opb = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("middiv_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("middiv_rst_valid", bus.out_valid, 0);
      chk("middiv_rst_busy", bus.busy, 0);
      chk("middiv_rst_result", bus.result, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end
    do_op("add_after_rst", 2'b00, 32'h0, 32'd3, 32'd4, 32'd7, 1'b0, 1);

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.alu_op_cls = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
      bus.instr     = {f7, 25'($urandom)};
      bus.opa       = pick();
      bus.opb       = pick();
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Parametrised successor to the combinational ALU decode. It takes the same 2-bit ALU operation class plus the raw instruction, decodes the operation, and executes it.
- Produces a registered result through a valid/ready handshake.
- Adds RV32M-style multiply/divide, with an iterative divider, so the core can stall on long-latency ops.
- Sits between register-read and writeback in the execute stage.

Parameters:
- XLEN, 32: operand/result width; power of 2, ≥8.
- DIV_UNROLL, 1: quotient bits resolved per divider cycle; must divide XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; transfer when in_valid&in_ready
- instr  in  32  instruction; uses funct3=[14:12], funct7=[31:25]
- alu_op_cls  in  2  00 ADD, 01 SUB, 10 R-type, 11 I-type
- opa  in  XLEN  operand A (rs1)
- opb  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; transfer when out_valid&out_ready
- result  out  XLEN  registered result
- illegal  out  1  qualifies result; set for undecodable op
- busy  out  1  high in DIV state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, result=0, illegal=0, busy=0, in_ready=0 while rst_n low. A reset mid-divide aborts it and discards the result.
- States:
  - IDLE: accepts operations.
  - DIV: iterating.
  - HOLD: result held awaiting out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready), so single-cycle ops sustain one per cycle.
- Decode:
  - 00 → ADD; 01 → SUB.
  - 10/11 funct3: 000 ADD (class 10 with funct7[5]=1 → SUB), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND.
  - Class 10 with funct7=0000001 → M-ext by funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Class 10 with funct7 not in {0000000, 0100000, 0000001} → illegal=1, result=0.
- Arithmetic:
  - Wrap-around modulo 2^XLEN.
  - Shift amount = opb[$clog2(XLEN)-1:0].
  - SLT/SLTU produce 0 or 1 zero-extended.
  - MUL* computed on a 2*XLEN product: MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned, and unsigned×unsigned operands respectively.
- Latency:
  - Non-divide ops accepted at cycle N → out_valid=1 at N+1.
  - Divide ops: IDLE→DIV, XLEN/DIV_UNROLL iterations, then out_valid at N+1+XLEN/DIV_UNROLL.
  - Signed divide runs on magnitudes, then fixes signs: quotient negative iff operand signs differ, remainder takes the dividend sign.
- Divide special cases resolve in 1 cycle (no DIV state):
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → opa.
  - Signed overflow (opa=100..0, opb=all-ones): DIV → opa; REM → 0.
- Output:
  - result/illegal are stable while out_valid && !out_ready.
  - The DIV completion cycle moves to HOLD if out_valid && !out_ready (cannot occur by in_ready rule, but HOLD is the defined landing state), otherwise to IDLE with out_valid=1.
  - out_valid clears on handshake unless a new op is accepted the same cycle.
- in_valid while in_ready=0: ignored, no state change.

Optional Feature:
- ALU_EXEC_MEXT_EN
- Defined: M-ext decode, multiplier, iterative divider and DIV state present, as above.
- Undefined: funct7=0000001 decodes as illegal (illegal=1, result=0, 1-cycle latency); DIV state is absent and busy is tied 0.

Test Plan:
- Reset then class 10, funct3=000, funct7=0100000, opa=5, opb=7 → next cycle out_valid=1, result=0xFFFFFFFE, illegal=0.
- Class 11, funct3=101, funct7[5]=1, opa=0x80000000, opb=0x24 (shamt=4) → result=0xF8000000; same with funct7[5]=0 → 0x08000000.
- Back-to-back ADD 1+1, ADD 2+2 with out_ready=1 → results 2, 4 on consecutive cycles; out_ready=0 on the second → 4 held and in_ready=0 until released.
- DIV opa=-7 (0xFFFFFFF9), opb=2, XLEN=32, DIV_UNROLL=1 → busy for 32 cycles, out_valid at N+33, result=0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIVU opa=9, opb=0 → 1 cycle, result=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Start DIV, assert rst_n=0 at iteration 10 → out_valid=0, busy=0, result=0 immediately; after release, an ADD 3+4 → 7 in 1 cycle.
